// File: rtl/serial_addsub.sv
// serial_addsub
//
// Bit-serial two's-complement adder/subtractor. A single full-adder cell is
// iterated once per clock over the operand bits, LSB first, with the carry
// held in a register between steps. Subtraction is A + ~B + 1: B is inverted
// when it is loaded and the carry is seeded with 1.
//
// Handshake: the block accepts an operation when start=1 is sampled while it
// is not busy (IDLE or DONE). busy is then high for WIDTH cycles and done
// pulses for one cycle when sum/cout/ovfl/zero update. start during RUN is
// ignored. busy and done are never high together.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous, active-high reset
//   start - request an operation (sampled on clk)
//   sub   - 0: A+B, 1: A-B (sampled with start)
//   a, b  - operands (sampled with start)
//   busy  - operation in progress
//   done  - one-cycle pulse when result and flags update
//   sum   - registered result
//   cout  - carry out of the MSB (for subtraction 1 = no borrow)
//   ovfl  - signed overflow
//   zero  - sum == 0
module serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovfl,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovfl_q, ovfl_d;
    logic               zero_q, zero_d;

    // Full-adder cell and the result word as it will look after this step.
    logic               sum_bit;
    logic               carry_nxt;
    logic [WIDTH-1:0]   res_nxt;
    logic               last_step;

    always_comb begin
        sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nxt = (a_sh_q[0] & b_sh_q[0]) | ((a_sh_q[0] ^ b_sh_q[0]) & carry_q);
        res_nxt   = {sum_bit, res_q[WIDTH-1:1]};
        last_step = (cnt_q == LAST_BIT);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = carry_nxt;
                res_d   = res_nxt;
                if (last_step) begin
                    // carry_q here is the carry into the MSB; overflow is
                    // its disagreement with the carry out of the MSB.
                    sum_d   = res_nxt;
                    cout_d  = carry_nxt;
                    ovfl_d  = carry_q ^ carry_nxt;
                    zero_d  = (res_nxt == '0);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            zero_q  <= zero_d;
        end
    end

    // Status outputs decode the state register directly, so they are glitch-free.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovfl = ovfl_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
    localparam int W = 16;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    logic         zero;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovfl  (ovfl),
        .zero  (zero)
    );

    // ---------------- scoreboard ----------------
    int           n_vec = 0;
    int           n_bad = 0;
    logic [W-1:0] last_sum;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain signed/unsigned integer arithmetic.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                                  output logic [W-1:0] s, output logic c, output logic v,
                                  output logic z);
        int sa, sb, r;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        r  = ms ? (sa - sb) : (sa + sb);
        s  = r[W-1:0];
        v  = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        c  = ms ? (ma >= mb) : ((int'(ma) + int'(mb)) >= (1 << W));
        z  = (s == '0);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation (caller is 1 time unit after an edge) and wait for done.
    // With scramble set, start is re-pulsed and operands changed mid-RUN.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                         input logic [W-1:0] es, input logic ec, input logic ev, input logic ez,
                         input bit scramble, output int lat);
        bit           hold_ok;
        bit           got;
        logic [W-1:0] exp_s;
        exp_q.push_back(es);
        a     = ia;
        b     = ib;
        sub   = is;
        start = 1'b1;
        tick();                      // start edge E0
        start = 1'b0;
        check("busy_after_start", {30'd0, busy, done}, 32'b10);
        hold_ok = 1'b1;
        got     = 1'b0;
        lat     = 0;
        for (int k = 1; k <= 3 * W && !got; k++) begin
            if (scramble && k == 5) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom_range(0, 1));
            end
            if (scramble && k == 7) start = 1'b0;
            tick();
            if (done) begin
                got = 1'b1;
                lat = k;
            end else begin
                if (!busy) hold_ok = 1'b0;
                if (sum !== last_sum) hold_ok = 1'b0;
            end
        end
        check("latency", lat, W);
        check("busy_done_at_done", {30'd0, busy, done}, 32'b01);
        check("sum_hold_during_run", {31'd0, hold_ok}, 32'd1);
        exp_s = (exp_q.size() > 0) ? exp_q.pop_front() : es;
        check("sum", sum, exp_s);
        check("cout", cout, ec);
        check("ovfl", ovfl, ev);
        check("zero", zero, ez);
        last_sum = exp_s;
    endtask

    // Count done pulses over n cycles with start low.
    task automatic count_done(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (done) cnt++;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int           lat;
        int           lat2;
        int           ndone;
        logic [W-1:0] ra, rb, es;
        logic         rs, ec, ev, ez;
        logic [W-1:0] corners[4];

        tbl[0] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        corners[0] = 16'h0000;
        corners[1] = 16'h8000;
        corners[2] = 16'h7FFF;
        corners[3] = 16'hFFFF;

        // Reset, with start held to show it is ignored under reset.
        rst   = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 16'h0000);
        check("rst_flags", {29'd0, cout, ovfl, zero}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);
        last_sum = '0;

        // Directed vectors.
        foreach (tbl[i]) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z, 1'b0, lat);
            tick();
        end

        // Randomized operations against the model, with corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) ra = corners[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rb = corners[$urandom_range(0, 3)];
            model(ra, rb, rs, es, ec, ev, ez);
            issue(ra, rb, rs, es, ec, ev, ez, ($urandom_range(0, 3) == 0), lat);
            tick();
        end

        // start and operands disturbed mid-RUN: result is from the original operands.
        issue(16'h00A5, 16'h0F0F, 1'b0, 16'h0FB4, 1'b0, 1'b0, 1'b0, 1'b1, lat);
        count_done(25, ndone);
        check("no_extra_done", ndone, 0);

        // Back-to-back: second start presented during the DONE cycle.
        issue(16'h0100, 16'h0001, 1'b0, 16'h0101, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, lat2);
        check("b2b_done_spacing", lat2 + 1, W + 1);
        tick();

        // Reset in the middle of RUN discards the operation.
        a     = 16'h4321;
        b     = 16'h1234;
        sub   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
        check("midrst_sum", sum, 16'h0000);
        check("midrst_flags", {29'd0, cout, ovfl, zero}, 32'd0);
        rst = 1'b0;
        count_done(25, ndone);
        check("midrst_no_done", ndone, 0);
        last_sum = '0;
        issue(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
